// File: rtl/serial_sub16_if.sv
// serial_sub16_if: start/operand/result bundle for serial_sub16 (master drives start, A, B, Bin; slave returns Diff, Bout, V, busy, done)
interface serial_sub16_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic [15:0] Diff;
  logic        Bout;
  logic        V;
  logic        busy;
  logic        done;
  modport master (output start, A, B, Bin, input Diff, Bout, V, busy, done);
  modport slave (input start, A, B, Bin, output Diff, Bout, V, busy, done);
endinterface

// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial 16-bit subtractor Diff = A - B - Bin, LSB first; ports clk, rst, bus (slave: start/A/B/Bin in, Diff/Bout/V/busy/done out)
module serial_sub16 (
  input logic           clk,
  input logic           rst,
  serial_sub16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, r_sr_q, r_sr_d;
  logic        br_q, br_d, a15_q, a15_d, b15_q, b15_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d, v_q, v_d;
  logic        d, br_nx;
  always_comb begin
    d      = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    br_nx  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    br_d    = br_q;
    a15_d   = a15_q;
    b15_d   = b15_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        a_sr_d  = bus.A;
        b_sr_d  = bus.B;
        br_d    = bus.Bin;
        cnt_d   = 4'd0;
        a15_d   = bus.A[15];
        b15_d   = bus.B[15];
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_sr_d = {d, r_sr_q[15:1]};
        br_d   = br_nx;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          diff_d  = {d, r_sr_q[15:1]};
          bout_d  = br_nx;
          v_d     = (a15_q != b15_q) && (d != a15_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      a15_q   <= 1'b0;
      b15_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      br_q    <= br_d;
      a15_q   <= a15_d;
      b15_q   <= b15_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: randomized and directed checks of serial_sub16 against an arithmetic reference model
module tb_serial_sub16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 1'b0;
  serial_sub16_if bus ();
  serial_sub16 dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: ph counts edges since the accepted start (1..16 busy, 17 done).
  int          ph = 0;
  logic [15:0] ma, mb;
  logic        mbin;
  logic [15:0] e_diff = '0;
  logic        e_bout = 1'b0, e_v = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      ph = 0; e_diff = '0; e_bout = 1'b0; e_v = 1'b0;
    end else if (ph == 0) begin
      if (bus.start) begin
        ph = 1; ma = bus.A; mb = bus.B; mbin = bus.Bin;
      end
    end else if (ph == 17) ph = 0;
    else begin
      ph++;
      if (ph == 17) begin
        int u, s;
        u = int'(ma) - int'(mb) - int'(mbin);
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e_diff = u[15:0];
        e_bout = int'(ma) < int'(mb) + int'(mbin);
        e_v    = (s < -32768) || (s > 32767);
      end
    end
  end
  always @(negedge clk) if (armed) begin
    chk("busy", 32'(bus.busy), 32'(ph >= 1 && ph <= 16));
    chk("done", 32'(bus.done), 32'(ph == 17));
    chk("diff", 32'(bus.Diff), 32'(e_diff));
    chk("bout", 32'(bus.Bout), 32'(e_bout));
    chk("v", 32'(bus.V), 32'(e_v));
  end
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Bin = 1'($urandom);
  endtask
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic bin, output int k);
    launch(a, b, bin);
    k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("timeout", 32'(k), 32'd16);
  endtask
  initial begin
    int k, nd;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
    chk("rst diff", 32'(bus.Diff), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    op(16'h1234, 16'h0234, 1'b0, k);
    chk("latency", 32'(k), 32'd16);
    chk("t1 diff", 32'(bus.Diff), 32'h1000);
    chk("t1 bout", 32'(bus.Bout), 32'h0);
    chk("t1 v", 32'(bus.V), 32'h0);
    op(16'h0000, 16'h0001, 1'b0, k);
    chk("t2 diff", 32'(bus.Diff), 32'hFFFF);
    chk("t2 bout", 32'(bus.Bout), 32'h1);
    chk("t2 v", 32'(bus.V), 32'h0);
    op(16'h0005, 16'h0005, 1'b1, k);
    chk("t3 diff", 32'(bus.Diff), 32'hFFFF);
    chk("t3 bout", 32'(bus.Bout), 32'h1);
    chk("t3 model", 32'(e_diff), 32'hFFFF);
    op(16'h8000, 16'h0001, 1'b0, k);
    chk("t4 diff", 32'(bus.Diff), 32'h7FFF);
    chk("t4 v", 32'(bus.V), 32'h1);
    chk("t4 bout", 32'(bus.Bout), 32'h0);
    op(16'h7FFF, 16'hFFFF, 1'b0, k);
    chk("t5 diff", 32'(bus.Diff), 32'h8000);
    chk("t5 v", 32'(bus.V), 32'h1);
    chk("t5 bout", 32'(bus.Bout), 32'h1);
    chk("t5 model v", 32'(e_v), 32'h1);
    launch(16'h00FF, 16'h000F, 1'b0);
    nd = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        nd++;
        chk("t6 diff", 32'(bus.Diff), 32'h00F0);
      end
      if (i < 16) chk("t6 hold", 32'(bus.Diff), 32'h8000);
      bus.start = (i == 5 || i == 16);
      if (bus.start) begin
        bus.A = 16'h1111; bus.B = 16'h2222;
      end
    end
    chk("t6 done count", 32'(nd), 32'd1);
    launch(16'h0001, 16'h0002, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7 busy", 32'(bus.busy), 32'h0);
    chk("t7 diff", 32'(bus.Diff), 32'h0);
    chk("t7 bout", 32'(bus.Bout), 32'h0);
    chk("t7 v", 32'(bus.V), 32'h0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("t7 no done", 32'(nd), 32'd0);
    op(16'hFFFF, 16'h0000, 1'b1, k);
    chk("t8 diff", 32'(bus.Diff), 32'hFFFE);
    chk("t8 bout", 32'(bus.Bout), 32'h0);
    for (int i = 0; i < 4000; i++) begin
      op(16'($urandom), 16'($urandom), 1'($urandom), k);
      if (i % 7 == 0) begin
        bus.start = 1'($urandom);
        bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Bin = 1'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while ((bus.busy || bus.done) && k < 40) begin
          @(negedge clk);
          k++;
        end
        if (k >= 40) chk("drain timeout", 32'(k), 32'd0);
      end
    end
    repeat (3) @(negedge clk);
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
